// File: rtl/sram_row_access_scheduler.sv
// Round-robin scheduler for one shared 8T SRAM column: sequences bl/wwl/rwl strobes,
// captures read data, and owns the column clock-gate and power-gate enables.
module sram_row_access_scheduler #(
   parameter int unsigned ADDR_W       = 3,
   parameter int unsigned STROBE_CYC   = 1,
   parameter int unsigned IDLE_TIMEOUT = 16,
   parameter int unsigned WAKE_CYC     = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     test_mode,
   input  logic                     req0_valid,
   input  logic                     req0_we,
   input  logic [ADDR_W-1:0]        req0_addr,
   input  logic                     req0_wdata,
   output logic                     req0_ready,
   input  logic                     req1_valid,
   input  logic                     req1_we,
   input  logic [ADDR_W-1:0]        req1_addr,
   input  logic                     req1_wdata,
   output logic                     req1_ready,
   output logic                     bl,
   output logic [(2**ADDR_W)-1:0]   wwl,
   output logic [(2**ADDR_W)-1:0]   rwl,
   input  logic [(2**ADDR_W)-1:0]   q,
   output logic                     rsp_valid,
   output logic                     rsp_id,
   output logic                     rsp_rdata,
   output logic                     en_clk,
   output logic                     en_pwr,
   output logic                     busy
);
   localparam int unsigned ROWS    = 2**ADDR_W;
   localparam int unsigned CNT_MAX = IDLE_TIMEOUT + STROBE_CYC + WAKE_CYC;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SETUP  = 3'd1;
   localparam logic [2:0] S_STROBE = 3'd2;
   localparam logic [2:0] S_DONE   = 3'd3;
   localparam logic [2:0] S_CGATE  = 3'd4;
   localparam logic [2:0] S_OFF    = 3'd5;
   localparam logic [2:0] S_WAKE   = 3'd6;

   logic [2:0]        state, state_d;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic              ptr, ptr_d;
   logic              op_we, op_we_d;
   logic              op_id, op_id_d;
   logic [ADDR_W-1:0] op_addr, op_addr_d;
   logic              bl_d, rsp_valid_d, rsp_id_d, rsp_rdata_d;
   logic              en_clk_d, en_pwr_d, busy_d;
   logic [ROWS-1:0]   wwl_d, rwl_d;
   logic              any_valid, gnt_id, in_idle;

   // Pointer's requester wins if valid, otherwise the other one
   assign any_valid  = req0_valid | req1_valid;
   assign gnt_id     = ptr ? req1_valid : ~req0_valid;
   assign in_idle    = (state == S_IDLE);
   assign req0_ready = in_idle & req0_valid & ~gnt_id;
   assign req1_ready = in_idle & req1_valid & gnt_id;

   always_comb begin
      state_d     = state;
      cnt_d       = cnt;
      ptr_d       = ptr;
      op_we_d     = op_we;
      op_id_d     = op_id;
      op_addr_d   = op_addr;
      bl_d        = bl;
      wwl_d       = '0;
      rwl_d       = '0;
      rsp_valid_d = 1'b0;
      rsp_id_d    = 1'b0;
      rsp_rdata_d = 1'b0;
      case (state)
         S_IDLE: begin
            if (any_valid) begin
               op_id_d   = gnt_id;
               op_we_d   = gnt_id ? req1_we   : req0_we;
               op_addr_d = gnt_id ? req1_addr : req0_addr;
               bl_d      = gnt_id ? (req1_we & req1_wdata) : (req0_we & req0_wdata);
               cnt_d     = '0;
               state_d   = S_SETUP;
            end else if (test_mode) begin
               cnt_d = '0;
            end else if (cnt == CNT_W'(IDLE_TIMEOUT - 1)) begin
               cnt_d   = '0;
               state_d = S_CGATE;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         S_SETUP: begin
            cnt_d   = '0;
            state_d = S_STROBE;
         end
         S_STROBE: begin
            if (cnt == CNT_W'(STROBE_CYC - 1)) begin
               cnt_d       = '0;
               state_d     = S_DONE;
               rsp_valid_d = 1'b1;
               rsp_id_d    = op_id;
               rsp_rdata_d = ~op_we & q[op_addr];
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         S_DONE: begin
            ptr_d   = ~op_id;
            bl_d    = 1'b0;
            state_d = S_IDLE;
         end
         S_CGATE: state_d = S_OFF;
         S_OFF: begin
            if (any_valid || test_mode) begin
               cnt_d   = '0;
               state_d = S_WAKE;
            end
         end
         S_WAKE: begin
            if (cnt == CNT_W'(WAKE_CYC - 1)) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
      // Outputs are registered, so they are derived from the state being entered
      if (state_d == S_STROBE) begin
         if (op_we_d) wwl_d = ROWS'(1) << op_addr_d;
         else         rwl_d = ROWS'(1) << op_addr_d;
      end
      en_pwr_d = (state_d != S_OFF);
      en_clk_d = (state_d != S_CGATE) && (state_d != S_OFF) && (state_d != S_WAKE);
      busy_d   = (state_d != S_IDLE) && (state_d != S_OFF);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         ptr       <= 1'b0;
         op_we     <= 1'b0;
         op_id     <= 1'b0;
         op_addr   <= '0;
         bl        <= 1'b0;
         wwl       <= '0;
         rwl       <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_rdata <= 1'b0;
         en_clk    <= 1'b1;
         en_pwr    <= 1'b1;
         busy      <= 1'b0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         ptr       <= ptr_d;
         op_we     <= op_we_d;
         op_id     <= op_id_d;
         op_addr   <= op_addr_d;
         bl        <= bl_d;
         wwl       <= wwl_d;
         rwl       <= rwl_d;
         rsp_valid <= rsp_valid_d;
         rsp_id    <= rsp_id_d;
         rsp_rdata <= rsp_rdata_d;
         en_clk    <= en_clk_d;
         en_pwr    <= en_pwr_d;
         busy      <= busy_d;
      end
   end
endmodule

// File: tb/tb_sram_row_access_scheduler.sv
// Scoreboard bench: a cycle-timeline reference model predicts grants, strobes, responses
// and power enables; a bitcell column model drives q from wwl/rwl/bl.
module tb_sram_row_access_scheduler;
   localparam int unsigned ADDR_W       = 3;
   localparam int unsigned ROWS         = 8;
   localparam int unsigned STROBE_CYC   = 1;
   localparam int unsigned IDLE_TIMEOUT = 16;
   localparam int unsigned WAKE_CYC     = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic test_mode = 1'b0;
   logic req0_valid = 1'b0, req0_we = 1'b0, req0_wdata = 1'b0;
   logic req1_valid = 1'b0, req1_we = 1'b0, req1_wdata = 1'b0;
   logic [ADDR_W-1:0] req0_addr = '0, req1_addr = '0;
   logic req0_ready, req1_ready, bl, rsp_valid, rsp_id, rsp_rdata, en_clk, en_pwr, busy;
   logic [ROWS-1:0] wwl, rwl, q;
   logic [ROWS-1:0] cells = 8'hA5;

   sram_row_access_scheduler #(
      .ADDR_W(ADDR_W), .STROBE_CYC(STROBE_CYC), .IDLE_TIMEOUT(IDLE_TIMEOUT), .WAKE_CYC(WAKE_CYC)
   ) dut (
      .clk(clk), .rst(rst), .test_mode(test_mode),
      .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_ready(req1_ready),
      .bl(bl), .wwl(wwl), .rwl(rwl), .q(q),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
      .en_clk(en_clk), .en_pwr(en_pwr), .busy(busy)
   );

   always #5 clk = ~clk;

   // Bitcell column: cells scramble when unpowered, write on wwl, read gated by rwl
   assign q = rwl & cells;
   always @(posedge clk) begin
      if (en_pwr === 1'b0) cells <= ROWS'($urandom);
      else for (int i = 0; i < ROWS; i++) if (wwl[i] === 1'b1) cells[i] <= bl;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int       t;
      logic     id;
      logic     we;
      logic [2:0] addr;
      logic     rdata;
      logic     chk;
   } exp_t;
   exp_t sb[$];

   int checks = 0, failures = 0;
   logic mon_on = 1'b0, rst_drv = 1'b1, last_acc = 1'b0;
   // Reference model state
   int ok_at = 0, idle_cnt = 0, down_c = -1, wake_w = -1;
   logic ptr_m = 1'b0;
   logic [ROWS-1:0] mem = '0, known = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic exp_en_clk(input int c);
      return !(down_c >= 0 && c >= down_c + 1 && (wake_w < 0 || c < wake_w + 1 + int'(WAKE_CYC)));
   endfunction

   function automatic logic exp_en_pwr(input int c);
      return !(down_c >= 0 && c >= down_c + 2 && (wake_w < 0 || c < wake_w + 1));
   endfunction

   // Monitor: registered outputs sampled just after the active edge
   task automatic mon();
      logic [ROWS-1:0] ew, er;
      logic ev;
      ew = '0; er = '0; ev = 1'b0;
      if (sb.size() > 0) begin
         if (cyc >= sb[0].t + 2 && cyc <= sb[0].t + 1 + int'(STROBE_CYC)) begin
            if (sb[0].we) ew = ROWS'(1) << sb[0].addr;
            else          er = ROWS'(1) << sb[0].addr;
         end
         ev = (cyc == sb[0].t + 2 + int'(STROBE_CYC));
      end
      chk("wwl", 32'(wwl), 32'(ew));
      chk("rwl", 32'(rwl), 32'(er));
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      if (ev) begin
         chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
         if (sb[0].chk) chk("rsp_rdata", 32'(rsp_rdata), 32'(sb[0].rdata));
         void'(sb.pop_front());
      end
      chk("en_clk", 32'(en_clk), 32'(exp_en_clk(cyc)));
      chk("en_pwr", 32'(en_pwr), 32'(exp_en_pwr(cyc)));
      chk("wl_onehot", 32'($onehot0(wwl | rwl) && !((|wwl) && (|rwl))), 32'd1);
      chk("wl_gated", 32'((|(wwl | rwl)) && !(en_pwr && en_clk)), 32'd0);
   endtask

   always @(posedge clk) begin
      #1;
      if (mon_on) mon();
   end

   // One stimulus cycle: drive inputs, advance the reference model, check ready
   task automatic step(input logic v0, input logic we0, input logic [2:0] a0, input logic d0,
                       input logic v1, input logic we1, input logic [2:0] a1, input logic d1,
                       input logic tm);
      logic g, acc, pidle;
      exp_t e;
      @(negedge clk);
      rst = rst_drv;
      req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
      req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
      test_mode = tm;
      #1;
      last_acc = 1'b0;
      if (rst_drv) begin
         foreach (sb[i]) if (sb[i].we) known[sb[i].addr] = 1'b0;
         sb.delete();
         ok_at = cyc + 1; idle_cnt = 0; down_c = -1; wake_w = -1; ptr_m = 1'b0;
         return;
      end
      if (down_c >= 0 && wake_w >= 0 && cyc >= wake_w + 1 + int'(WAKE_CYC)) begin
         down_c = -1; wake_w = -1;
      end
      pidle = (down_c < 0) && (cyc >= ok_at);
      g = ptr_m ? (v1 ? 1'b1 : 1'b0) : (v0 ? 1'b0 : 1'b1);
      acc = pidle && (v0 || v1);
      if (mon_on) begin
         chk("req0_ready", 32'(req0_ready), 32'(acc && !g));
         chk("req1_ready", 32'(req1_ready), 32'(acc && g));
      end
      if (acc) begin
         e.t = cyc; e.id = g;
         e.we = g ? we1 : we0; e.addr = g ? a1 : a0;
         if (e.we) begin
            mem[e.addr] = g ? d1 : d0; known[e.addr] = 1'b1;
            e.rdata = 1'b0; e.chk = 1'b1;
         end else begin
            e.rdata = mem[e.addr]; e.chk = known[e.addr];
         end
         sb.push_back(e);
         ptr_m = ~g;
         ok_at = cyc + int'(STROBE_CYC) + 3;
         idle_cnt = 0;
         last_acc = 1'b1;
      end else if (pidle) begin
         if (tm) idle_cnt = 0;
         else begin
            idle_cnt++;
            if (idle_cnt == int'(IDLE_TIMEOUT)) begin
               down_c = cyc; idle_cnt = 0; known = '0;
            end
         end
      end else if (down_c >= 0 && cyc >= down_c + 2 && wake_w < 0 && (v0 || v1 || tm)) begin
         wake_w = cyc;
      end
   endtask

   task automatic nop(input logic tm);
      step(0, 0, 3'd0, 0, 0, 0, 3'd0, 0, tm);
   endtask

   task automatic req(input logic id, input logic we, input logic [2:0] a, input logic d);
      int n;
      n = 0;
      do begin
         if (id) step(0, 0, 3'd0, 0, 1, we, a, d, 0);
         else    step(1, we, a, d, 0, 0, 3'd0, 0, 0);
         n++;
      end while (!last_acc && n < 60);
      if (!last_acc) begin
         checks++; failures++;
         $display("FAIL req_timeout cyc=%0d got=no_accept exp=accept", cyc);
      end
   endtask

   initial begin
      int dens, len, tm;
      rst_drv = 1'b1;
      nop(0);
      mon_on = 1'b1;
      nop(0);
      rst_drv = 1'b0;

      // Write then read back row 5
      req(0, 1, 3'd5, 1);
      repeat (4) nop(0);
      req(1, 0, 3'd5, 0);
      repeat (4) nop(0);

      // Both requesters continuously valid: alternating grants
      repeat (40) step(1, 1'($urandom), 3'($urandom), 1'($urandom),
                       1, 1'($urandom), 3'($urandom), 1'($urandom), 0);

      // Randomized traffic with idle gaps, some long enough to power down
      for (int b = 0; b < 40; b++) begin
         tm = ($urandom % 4 == 0);
         dens = $urandom_range(1, 5);
         len = $urandom_range(10, 40);
         for (int k = 0; k < len; k++)
            step(($urandom % 5) < dens, 1'($urandom), 3'($urandom), 1'($urandom),
                 ($urandom % 5) < dens, 1'($urandom), 3'($urandom), 1'($urandom), 1'(tm));
         repeat ($urandom_range(0, 25)) nop(0);
      end

      // Power down then wake on a request
      repeat (25) nop(0);
      req(0, 0, 3'd2, 0);
      repeat (5) nop(0);
      req(1, 1, 3'd6, 0);
      repeat (4) nop(0);
      req(0, 0, 3'd6, 0);
      repeat (4) nop(0);

      // test_mode keeps the column powered
      repeat (50) nop(1);

      // Power down then wake via test_mode
      repeat (25) nop(0);
      repeat (5) nop(1);
      repeat (5) nop(0);

      // Reset during the strobe of a write
      req(0, 1, 3'd3, 1);
      nop(0);
      rst_drv = 1'b1;
      nop(0);
      rst_drv = 1'b0;
      repeat (4) nop(0);
      req(1, 1, 3'd4, 1);
      repeat (4) nop(0);
      req(0, 0, 3'd4, 0);
      repeat (6) nop(0);

      if (sb.size() != 0) begin
         checks++; failures++;
         $display("FAIL sb_drain cyc=%0d got=%0d exp=0", cyc, sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
